// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Shares the register-file write port between the in-order
//               pipeline writeback and a queued long-latency unit. Pipeline
//               writes always win; queued results drain on idle slots, and a
//               starvation counter requests a writeback bubble.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_p_wreg,
    input  logic                       i_p_wfpr,
    input  logic [4:0]                 i_p_rn,
    input  logic [31:0]                i_p_data,
    input  logic                       i_l_valid,
    input  logic                       i_l_fpr,
    input  logic [4:0]                 i_l_rn,
    input  logic [31:0]                i_l_data,
    output logic                       o_l_ready,
    output logic                       o_rf_we,
    output logic                       o_fpr_we,
    output logic [4:0]                 o_wr_rn,
    output logic [31:0]                o_wr_data,
    output logic                       o_wr_src,
    output logic                       o_stall_req,
    output logic [$clog2(DEPTH):0]     o_pend_cnt
);

    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW:0]   c_DEPTH    = (AW+1)'(DEPTH);
    localparam logic [7:0]    c_MAX_WAIT = 8'(MAX_WAIT);

    // Queue storage (data only; occupancy is tracked by the count register)
    logic              r_fpr_mem  [DEPTH];
    logic [4:0]        r_rn_mem   [DEPTH];
    logic [31:0]       r_data_mem [DEPTH];

    logic [AW-1:0]     r_rd_ptr;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW:0]       r_cnt;
    logic [7:0]        r_wait;

    logic              w_pbusy;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;

    assign w_pbusy = i_p_wreg | i_p_wfpr;
    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == c_DEPTH);
    // Push readiness looks only at current occupancy, so a same-cycle pop
    // never opens a slot in a full queue.
    assign w_push  = i_l_valid & ~w_full;
    assign w_pop   = ~w_pbusy & ~w_empty;

    assign o_l_ready   = ~w_full;
    assign o_pend_cnt  = r_cnt;
    assign o_stall_req = (r_wait == c_MAX_WAIT);

    // Capture an accepted long-latency result at the write pointer
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fpr_mem[r_wr_ptr]  <= i_l_fpr;
            r_rn_mem[r_wr_ptr]   <= i_l_rn;
            r_data_mem[r_wr_ptr] <= i_l_data;
        end
    end

    // Circular pointers and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Starvation counter: counts consecutive cycles a queued head is blocked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait <= 8'd0;
        end else if (w_empty || w_pop) begin
            r_wait <= 8'd0;
        end else if (w_pbusy && (r_wait != c_MAX_WAIT)) begin
            r_wait <= r_wait + 8'd1;
        end
    end

    // Write-port mux: pipeline first, then queue head, else idle
    always_comb begin
        o_rf_we   = 1'b0;
        o_fpr_we  = 1'b0;
        o_wr_rn   = 5'd0;
        o_wr_data = 32'd0;
        o_wr_src  = 1'b0;
        if (rst_n) begin
            if (w_pbusy) begin
                o_rf_we   = i_p_wreg;
                o_fpr_we  = i_p_wfpr;
                o_wr_rn   = i_p_rn;
                o_wr_data = i_p_data;
            end else if (!w_empty) begin
                o_rf_we   = ~r_fpr_mem[r_rd_ptr];
                o_fpr_we  = r_fpr_mem[r_rd_ptr];
                o_wr_rn   = r_rn_mem[r_rd_ptr];
                o_wr_data = r_data_mem[r_rd_ptr];
                o_wr_src  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Self-checking bench for wb_port_arbiter. A queue-based model
//               predicts every output each cycle; directed literal checks
//               pin the model to hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p_wreg, p_wfpr;
    logic [4:0]  p_rn;
    logic [31:0] p_data;
    logic        l_valid, l_fpr;
    logic [4:0]  l_rn;
    logic [31:0] l_data;
    logic        l_ready, rf_we, fpr_we, wr_src, stall_req;
    logic [4:0]  wr_rn;
    logic [31:0] wr_data;
    logic [2:0]  pend_cnt;

    wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_p_wreg    (p_wreg),
        .i_p_wfpr    (p_wfpr),
        .i_p_rn      (p_rn),
        .i_p_data    (p_data),
        .i_l_valid   (l_valid),
        .i_l_fpr     (l_fpr),
        .i_l_rn      (l_rn),
        .i_l_data    (l_data),
        .o_l_ready   (l_ready),
        .o_rf_we     (rf_we),
        .o_fpr_we    (fpr_we),
        .o_wr_rn     (wr_rn),
        .o_wr_data   (wr_data),
        .o_wr_src    (wr_src),
        .o_stall_req (stall_req),
        .o_pend_cnt  (pend_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        fpr;
        logic [4:0]  rn;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    int   blocked = 0;   // consecutive cycles the oldest entry was refused
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    endtask

    // Predict every output from the queue contents and the current inputs
    task automatic check_model();
        logic        pb, e_rf, e_fpr, e_src;
        logic [4:0]  e_rn;
        logic [31:0] e_data;
        pb = p_wreg | p_wfpr;
        e_rf = 1'b0; e_fpr = 1'b0; e_src = 1'b0; e_rn = 5'd0; e_data = 32'd0;
        if (pb) begin
            e_rf = p_wreg; e_fpr = p_wfpr; e_rn = p_rn; e_data = p_data;
        end else if (q.size() > 0) begin
            e_rf = ~q[0].fpr; e_fpr = q[0].fpr; e_rn = q[0].rn; e_data = q[0].data; e_src = 1'b1;
        end
        chk("rf_we",     32'(rf_we),     32'(e_rf));
        chk("fpr_we",    32'(fpr_we),    32'(e_fpr));
        chk("wr_src",    32'(wr_src),    32'(e_src));
        chk("wr_rn",     32'(wr_rn),     32'(e_rn));
        chk("wr_data",   wr_data,        e_data);
        chk("l_ready",   32'(l_ready),   32'(q.size() < DEPTH));
        chk("pend_cnt",  32'(pend_cnt),  q.size());
        chk("stall_req", 32'(stall_req), 32'(blocked >= MAX_WAIT));
    endtask

    // Advance the model by one clock using the inputs held through the edge
    task automatic model_update();
        logic pb;
        int   n;
        ent_t e;
        pb = p_wreg | p_wfpr;
        n  = q.size();
        if (!pb && n > 0) begin
            void'(q.pop_front());
            blocked = 0;
        end else if (n == 0) begin
            blocked = 0;
        end else begin
            blocked++;
        end
        if (l_valid && n < DEPTH) begin
            e.fpr = l_fpr; e.rn = l_rn; e.data = l_data;
            q.push_back(e);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_model();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_p(input logic wreg, input logic wfpr, input logic [4:0] rn, input logic [31:0] d);
        p_wreg = wreg; p_wfpr = wfpr; p_rn = rn; p_data = d;
    endtask

    task automatic set_l(input logic v, input logic f, input logic [4:0] rn, input logic [31:0] d);
        l_valid = v; l_fpr = f; l_rn = rn; l_data = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        // Reset with the pipeline requesting a write: enables stay low
        rst_n = 1'b0;
        set_p(1'b1, 1'b0, 5'd1, 32'h1234);
        set_l(1'b0, 1'b0, 5'd0, 32'd0);
        #1;
        chk("rst_rf_we",    32'(rf_we),     32'd0);
        chk("rst_fpr_we",   32'(fpr_we),    32'd0);
        chk("rst_pend",     32'(pend_cnt),  32'd0);
        chk("rst_l_ready",  32'(l_ready),   32'd1);
        chk("rst_stall",    32'(stall_req), 32'd0);
        chk("rst_wr_src",   32'(wr_src),    32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_p(1'b0, 1'b0, 5'd0, 32'd0);
        q.delete(); blocked = 0;

        // Idle drain: push in cycle 0, written in cycle 1, empty in cycle 2
        set_l(1'b1, 1'b0, 5'd5, 32'h11111111);
        cycle();
        set_l(1'b0, 1'b0, 5'd0, 32'd0);
        #1;
        chk("drain_rf_we",  32'(rf_we),  32'd1);
        chk("drain_rn",     32'(wr_rn),  32'd5);
        chk("drain_data",   wr_data,     32'h11111111);
        chk("drain_src",    32'(wr_src), 32'd1);
        cycle();
        chk("drain_pend",   32'(pend_cnt), 32'd0);

        // Priority: pipeline FP write wins over queued r7
        set_l(1'b1, 1'b0, 5'd7, 32'h77777777);
        cycle();
        set_l(1'b0, 1'b0, 5'd0, 32'd0);
        set_p(1'b0, 1'b1, 5'd3, 32'hAAAA0000);
        #1;
        chk("prio_fpr_we",  32'(fpr_we), 32'd1);
        chk("prio_rf_we",   32'(rf_we),  32'd0);
        chk("prio_rn",      32'(wr_rn),  32'd3);
        chk("prio_src",     32'(wr_src), 32'd0);
        cycle();
        chk("prio_retain",  32'(pend_cnt), 32'd1);
        set_p(1'b0, 1'b0, 5'd0, 32'd0);
        #1;
        chk("prio_next_rn",   32'(wr_rn),  32'd7);
        chk("prio_next_data", wr_data,     32'h77777777);
        chk("prio_next_src",  32'(wr_src), 32'd1);
        cycle();

        // Full: four pushes while the pipeline is busy, fifth refused
        set_p(1'b1, 1'b0, 5'd1, 32'h00000001);
        for (int i = 0; i < 4; i++) begin
            set_l(1'b1, 1'(i), 5'(10 + i), 32'hC0DE0000 + 32'(i));
            cycle();
        end
        chk("full_ready",   32'(l_ready),  32'd0);
        chk("full_pend",    32'(pend_cnt), 32'd4);
        set_l(1'b1, 1'b0, 5'd20, 32'h0000BAD0);
        cycle();
        chk("full_ignored", 32'(pend_cnt), 32'd4);
        // Idle slot with l_valid: pop happens, push does not
        set_p(1'b0, 1'b0, 5'd0, 32'd0);
        set_l(1'b1, 1'b0, 5'd21, 32'h0000BAD1);
        #1;
        chk("full_pop_src",  32'(wr_src), 32'd1);
        chk("full_pop_data", wr_data,     32'hC0DE0000);
        cycle();
        chk("full_pop_pend", 32'(pend_cnt), 32'd3);

        // Drain, then refill across the pointer wrap and drain again
        set_l(1'b0, 1'b0, 5'd0, 32'd0);
        repeat (3) cycle();
        set_p(1'b1, 1'b0, 5'd2, 32'h00000002);
        for (int i = 0; i < 6; i++) begin
            set_l(1'b1, 1'b0, 5'(i), 32'h5A5A0000 + 32'(i));
            cycle();
        end
        set_l(1'b0, 1'b0, 5'd0, 32'd0);
        set_p(1'b0, 1'b0, 5'd0, 32'd0);
        #1;
        chk("wrap_head",    wr_data, 32'h5A5A0000);
        repeat (4) cycle();
        chk("wrap_empty",   32'(pend_cnt), 32'd0);

        // Starvation: one entry blocked for MAX_WAIT cycles
        set_l(1'b1, 1'b0, 5'd9, 32'h99999999);
        cycle();
        set_l(1'b0, 1'b0, 5'd0, 32'd0);
        set_p(1'b1, 1'b0, 5'd2, 32'h00002222);
        for (int i = 0; i < MAX_WAIT; i++) begin
            #1;
            chk("starve_low", 32'(stall_req), 32'd0);
            cycle();
        end
        set_p(1'b0, 1'b0, 5'd0, 32'd0);
        #1;
        chk("starve_high",  32'(stall_req), 32'd1);
        chk("starve_rn",    32'(wr_rn),     32'd9);
        cycle();
        chk("starve_clear", 32'(stall_req), 32'd0);

        // FP routing on an idle pipeline
        set_l(1'b1, 1'b1, 5'd31, 32'hDEADBEEF);
        cycle();
        set_l(1'b0, 1'b0, 5'd0, 32'd0);
        #1;
        chk("fp_fpr_we",    32'(fpr_we), 32'd1);
        chk("fp_rf_we",     32'(rf_we),  32'd0);
        chk("fp_rn",        32'(wr_rn),  32'd31);
        chk("fp_data",      wr_data,     32'hDEADBEEF);
        cycle();

        // Mixed traffic against the model
        for (int i = 0; i < 60; i++) begin
            set_p(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                  5'($urandom), 32'($urandom));
            set_l(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom), 32'($urandom));
            cycle();
        end

        // Reset mid-queue: discard everything without a clock edge
        set_l(1'b0, 1'b0, 5'd0, 32'd0);
        set_p(1'b0, 1'b0, 5'd0, 32'd0);
        repeat (5) cycle();
        set_p(1'b1, 1'b0, 5'd4, 32'h00004444);
        for (int i = 0; i < 3; i++) begin
            set_l(1'b1, 1'b0, 5'(i + 1), 32'h33330000 + 32'(i));
            cycle();
        end
        chk("mid_pend_pre", 32'(pend_cnt), 32'd3);
        set_l(1'b0, 1'b0, 5'd0, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_pend",     32'(pend_cnt),  32'd0);
        chk("mid_ready",    32'(l_ready),   32'd1);
        chk("mid_stall",    32'(stall_req), 32'd0);
        chk("mid_rf_we",    32'(rf_we),     32'd0);
        chk("mid_fpr_we",   32'(fpr_we),    32'd0);
        q.delete(); blocked = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_p(1'b0, 1'b0, 5'd0, 32'd0);
        repeat (2) cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
